depatchifier: RTL and testbench
===============================

# depatchifier

Inverse of the ViT front-end patchifier. Accepts a stream of flattened patch vectors, one patch per beat, over a valid/ready handshake. Scatters each pixel back to its (i, j) image position in an internal buffer. After the last patch it publishes the reassembled image with the same three-state en / output_taken handshake the patchifier uses. Used for reconstruction, debug readback and round-trip checks of the patch path.

## Interface
- CHANNEL_SIZE, 8, bits per colour channel
- NUM_CHANNELS, 3, channels per pixel
- PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, bits per pixel
- IMG_WIDTH, 64, first image index range (i)
- IMG_HEIGHT, 64, second image index range (j)
- PATCH_SIZE, 4, patch edge in pixels
- PATCHES_IN_ROW, IMG_WIDTH/PATCH_SIZE, patch-grid stride
- TOTAL_NUM_PATCHES, (IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), patches per image
- PATCH_VECTOR_SIZE, PATCH_SIZE*PATCH_SIZE, pixels per patch

Ports:
- clk  in  1  clock; one clock domain
- reset  in  1  synchronous, active-high reset
- en  in  1  start request, sampled only in IDLE
- in_valid  in  1  in_patch/in_last valid
- in_ready  out  1  block can accept a patch this cycle
- in_patch  in  [PIXEL_WIDTH-1:0] x [PATCH_VECTOR_SIZE]  one flattened patch; element p = position index
- in_last  in  1  producer marks final patch of image
- output_taken  in  1  consumer has read image_out
- state  out  2  00 IDLE, 01 COLLECT, 10 DONE
- image_out  out  [PIXEL_WIDTH-1:0] x [IMG_WIDTH][IMG_HEIGHT]  reassembled image
- patch_count  out  $clog2(TOTAL_NUM_PATCHES+1)  patches accepted in current image
- err_last  out  1  sticky in_last / count mismatch flag

## Operation
- Mapping: patch k, position p → image_out[i][j].
  - i = (k/PATCHES_IN_ROW)*PATCH_SIZE + p/PATCH_SIZE
  - j = (k%PATCHES_IN_ROW)*PATCH_SIZE + p%PATCH_SIZE
  - This is the exact inverse of patchify, where patch = (i/PATCH_SIZE)*PATCHES_IN_ROW + j/PATCH_SIZE and position = (i%PATCH_SIZE)*PATCH_SIZE + j%PATCH_SIZE.
- Patches arrive in ascending order; k = patch_count at acceptance. There is no index on the bus.
- Accept = in_valid && in_ready. On accept, all PATCH_VECTOR_SIZE pixels are written to the internal buffer in one cycle, and patch_count increments.
- FSM:
  - IDLE→COLLECT when en. This clears patch_count and err_last.
  - COLLECT→DONE on accept with patch_count == TOTAL_NUM_PATCHES-1. The same edge copies the buffer, including the final patch, to image_out.
  - DONE→IDLE when output_taken. The same edge zeroes image_out.
  - Illegal state 11→IDLE.
- in_ready = (state == COLLECT), combinational from state only. It never depends on in_valid.
- err_last is set on any accept where in_last != (patch_count == TOTAL_NUM_PATCHES-1).
  - Completion is governed by the count only. An early in_last does not end collection; a missing in_last still completes.
- Buffer pixels not rewritten keep stale values. Every position is written once per image, so no clear is needed.

## Timing
- Reset (any state, including mid-COLLECT):
  - state=00, patch_count=0, err_last=0, image_out all zero
  - in_ready=0 in the same cycle reset is held (state is IDLE)
  - partial image discarded; buffer contents don't care
- Throughput: one patch per cycle while in COLLECT; TOTAL_NUM_PATCHES cycles minimum per image.
- Latency: final accept at edge N → state=10 and image_out valid after edge N; in_ready=0 from then.
- image_out is stable for the whole of DONE. It is zero in IDLE and COLLECT after a completed handoff.
- en is ignored in COLLECT and DONE. output_taken is ignored outside DONE.
- output_taken and en asserted together in DONE → IDLE only; en must be reasserted in IDLE.
- in_valid high in IDLE or DONE: no accept, no count change, no error.

## Test plan
Bench config: IMG_WIDTH=IMG_HEIGHT=8, PATCH_SIZE=4 (4 patches x 16). Pixel for patch k, position p = {8'h00, k[7:0], p[7:0]}.
- Full image, in_valid continuous, in_last on k=3:
  - 4 accepts, state=10 one edge after the 4th
  - image_out[5][2]=24'h000206, image_out[7][7]=24'h00030F, image_out[0][4]=24'h000100
  - err_last=0
- Backpressure/bubbles: in_valid toggled 1,0,0,1,… → same image; patch_count holds on idle cycles; completes only on the 4th accept.
- in_last on k=1 and none on k=3 → err_last=1 after the 2nd accept; completion still on the 4th; image_out as above; next en clears err_last.
- Handoff: hold DONE 10 cycles → image_out stable, in_ready=0. Pulse output_taken with en=1 → state=00, image_out all zero, stays IDLE until en.
- Reset after 2 accepts → state=00, patch_count=0, image_out zero. A new full image then reassembles correctly with no residue.
- en and in_valid in DONE/IDLE without protocol → no accept, patch_count unchanged.

Source files
------------

// File: rtl/depatchifier.sv
// depatchifier: reassembles a stream of flattened ViT patches back into an
// image buffer and publishes it with the IDLE/COLLECT/DONE handshake used by
// the patchifier.
module depatchifier #(
    parameter int unsigned CHANNEL_SIZE      = 8,
    parameter int unsigned NUM_CHANNELS      = 3,
    parameter int unsigned PIXEL_WIDTH       = CHANNEL_SIZE * NUM_CHANNELS,
    parameter int unsigned IMG_WIDTH         = 64,
    parameter int unsigned IMG_HEIGHT        = 64,
    parameter int unsigned PATCH_SIZE        = 4,
    parameter int unsigned PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE,
    parameter int unsigned TOTAL_NUM_PATCHES = (IMG_WIDTH / PATCH_SIZE) * (IMG_HEIGHT / PATCH_SIZE),
    parameter int unsigned PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     en,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [PIXEL_WIDTH-1:0]                   in_patch [PATCH_VECTOR_SIZE],
    input  logic                                     in_last,
    input  logic                                     output_taken,
    output logic [1:0]                               state,
    output logic [PIXEL_WIDTH-1:0]                   image_out [IMG_WIDTH][IMG_HEIGHT],
    output logic [$clog2(TOTAL_NUM_PATCHES+1)-1:0]   patch_count,
    output logic                                     err_last
);

    localparam int unsigned CNT_W = $clog2(TOTAL_NUM_PATCHES + 1);
    localparam int unsigned PIX_W = (PATCH_VECTOR_SIZE > 1) ? $clog2(PATCH_VECTOR_SIZE) : 1;
    localparam int unsigned IW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned JW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_COLLECT = 2'b01;
    localparam logic [1:0] S_DONE    = 2'b10;

    logic [1:0]             state_q;
    logic [CNT_W-1:0]       count_q;
    logic                   err_q;
    logic [PIXEL_WIDTH-1:0] img_q [IMG_WIDTH][IMG_HEIGHT];
    logic [PIXEL_WIDTH-1:0] buf_q [IMG_WIDTH][IMG_HEIGHT];
    logic [PIXEL_WIDTH-1:0] buf_d [IMG_WIDTH][IMG_HEIGHT];

    logic        accept;
    logic        is_final;
    int unsigned krow;
    int unsigned kcol;

    assign in_ready    = (state_q == S_COLLECT);
    assign accept      = in_valid && in_ready;
    assign is_final    = (count_q == CNT_W'(TOTAL_NUM_PATCHES - 1));
    assign krow        = 32'(count_q) / PATCHES_IN_ROW;
    assign kcol        = 32'(count_q) % PATCHES_IN_ROW;
    assign state       = state_q;
    assign patch_count = count_q;
    assign err_last    = err_q;
    assign image_out   = img_q;

    // Next buffer: every pixel belonging to the patch being accepted takes its
    // element of in_patch; all others hold. Selecting per pixel by patch
    // membership avoids variable-indexed writes into the image array.
    always_comb begin
        buf_d = buf_q;
        for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
            for (int unsigned j = 0; j < IMG_HEIGHT; j++) begin
                if (accept && (i / PATCH_SIZE == krow) && (j / PATCH_SIZE == kcol)) begin
                    buf_d[IW'(i)][JW'(j)] =
                        in_patch[PIX_W'((i % PATCH_SIZE) * PATCH_SIZE + (j % PATCH_SIZE))];
                end
            end
        end
    end

    // Scatter buffer; no reset needed since every pixel is rewritten per image.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    // Control FSM, counters, error flag and published image.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < IMG_WIDTH; i++)
                for (int unsigned j = 0; j < IMG_HEIGHT; j++)
                    img_q[IW'(i)][JW'(j)] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q <= S_COLLECT;
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        count_q <= count_q + CNT_W'(1);
                        if (in_last != is_final)
                            err_q <= 1'b1;
                        if (is_final) begin
                            state_q <= S_DONE;
                            // buf_d already holds the final patch
                            img_q   <= buf_d;
                        end
                    end
                end
                S_DONE: begin
                    if (output_taken) begin
                        state_q <= S_IDLE;
                        for (int unsigned i = 0; i < IMG_WIDTH; i++)
                            for (int unsigned j = 0; j < IMG_HEIGHT; j++)
                                img_q[IW'(i)][JW'(j)] <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_depatchifier.sv
// tb_depatchifier: directed checks of patch scatter, handshake, error flag,
// handoff and reset on an 8x8 image of 4x4 patches.
module tb_depatchifier;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int PS = 4;
    localparam int NP = 4;
    localparam int PV = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_patch [PV];
    logic        in_last = 1'b0;
    logic        output_taken = 1'b0;
    logic [1:0]  state;
    logic [23:0] image_out [W][H];
    logic [2:0]  patch_count;
    logic        err_last;

    int vectors = 0;
    int miscompares = 0;

    depatchifier #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .PATCH_SIZE(PS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_patch    (in_patch),
        .in_last     (in_last),
        .output_taken(output_taken),
        .state       (state),
        .image_out   (image_out),
        .patch_count (patch_count),
        .err_last    (err_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_pix(input logic [7:0] seed, input int i, input int j);
        int k;
        int p;
        k = (i / PS) * (W / PS) + j / PS;
        p = (i % PS) * PS + j % PS;
        return {seed, 8'(k), 8'(p)};
    endfunction

    task automatic check_image(input logic [7:0] seed, input string name);
        int bad = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                if (image_out[i][j] !== exp_pix(seed, i, j)) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s: %0d pixels differ (got [0][0]=%h, want %h)",
                     name, bad, image_out[0][0], exp_pix(seed, 0, 0));
        end
    endtask

    task automatic check_zero(input string name);
        int bad = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                if (image_out[i][j] !== 24'h0) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s: %0d pixels nonzero, want all zero", name, bad);
        end
    endtask

    task automatic check_sig(input string name, input logic [3:0] got, input logic [3:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Start an image and feed all four patches; bubbles idle cycles between accepts.
    task automatic collect(input logic [7:0] seed, input int bubbles, input int last_k);
        logic exp_err;
        exp_err = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        check_sig("start_state", {2'b0, state}, 4'h1);
        check_sig("start_count", {1'b0, patch_count}, 4'h0);
        for (int k = 0; k < NP; k++) begin
            for (int p = 0; p < PV; p++) in_patch[p] = {seed, 8'(k), 8'(p)};
            in_last  = (k == last_k);
            in_valid = 1'b1;
            check_sig("in_ready_collect", {3'b0, in_ready}, 4'h1);
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            if ((k == last_k) != (k == NP - 1)) exp_err = 1'b1;
            check_sig("accept_count", {1'b0, patch_count}, 4'(k + 1));
            check_sig("accept_state", {2'b0, state}, (k == NP - 1) ? 4'h2 : 4'h1);
            check_sig("accept_err", {3'b0, err_last}, {3'b0, exp_err});
            if (k < NP - 1) begin
                for (int b = 0; b < bubbles; b++) begin
                    tick();
                    check_sig("bubble_count", {1'b0, patch_count}, 4'(k + 1));
                    check_sig("bubble_state", {2'b0, state}, 4'h1);
                end
            end
        end
        check_sig("done_in_ready", {3'b0, in_ready}, 4'h0);
    endtask

    task automatic take_output();
        output_taken = 1'b1;
        tick();
        output_taken = 1'b0;
        check_sig("taken_state", {2'b0, state}, 4'h0);
        check_zero("taken_image_zero");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        check_sig("reset_state", {2'b0, state}, 4'h0);
        check_sig("reset_in_ready", {3'b0, in_ready}, 4'h0);
        check_sig("reset_count", {1'b0, patch_count}, 4'h0);
        check_sig("reset_err", {3'b0, err_last}, 4'h0);
        check_zero("reset_image_zero");
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_image();
        collect(8'h00, 0, 3);
        vectors++;
        if (image_out[5][2] !== 24'h000206) begin
            miscompares++;
            $display("FAIL pix_5_2: got %h want 000206", image_out[5][2]);
        end
        vectors++;
        if (image_out[7][7] !== 24'h00030F) begin
            miscompares++;
            $display("FAIL pix_7_7: got %h want 00030f", image_out[7][7]);
        end
        vectors++;
        if (image_out[0][4] !== 24'h000100) begin
            miscompares++;
            $display("FAIL pix_0_4: got %h want 000100", image_out[0][4]);
        end
        check_sig("full_err", {3'b0, err_last}, 4'h0);
        check_image(8'h00, "full_image");
    endtask

    // DONE held with stray en/in_valid, then output_taken together with en.
    task automatic test_handoff();
        for (int c = 0; c < 10; c++) begin
            en       = (c % 2 == 0);
            in_valid = 1'b1;
            tick();
            check_sig("done_hold_state", {2'b0, state}, 4'h2);
            check_sig("done_hold_ready", {3'b0, in_ready}, 4'h0);
            check_sig("done_hold_count", {1'b0, patch_count}, 4'h4);
        end
        in_valid = 1'b0;
        check_image(8'h00, "done_stable_image");
        en = 1'b1;
        take_output();
        en = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_sig("idle_stay_state", {2'b0, state}, 4'h0);
            check_sig("idle_count_hold", {1'b0, patch_count}, 4'h4);
            check_sig("idle_err", {3'b0, err_last}, 4'h0);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        collect(8'h00, 2, 3);
        check_sig("bubble_err", {3'b0, err_last}, 4'h0);
        check_image(8'h00, "bubble_image");
        take_output();
    endtask

    task automatic test_err_last();
        collect(8'h00, 0, 1);
        check_sig("errlast_sticky", {3'b0, err_last}, 4'h1);
        check_image(8'h00, "errlast_image");
        take_output();
        check_sig("errlast_idle_hold", {3'b0, err_last}, 4'h1);
        en = 1'b1;
        tick();
        en = 1'b0;
        check_sig("errlast_cleared", {3'b0, err_last}, 4'h0);
        check_sig("errlast_restart_state", {2'b0, state}, 4'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < PV; p++) in_patch[p] = {8'h77, 8'(k), 8'(p)};
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check_sig("mid_count_before", {1'b0, patch_count}, 4'h2);
        reset = 1'b1;
        tick();
        check_sig("mid_reset_state", {2'b0, state}, 4'h0);
        check_sig("mid_reset_ready", {3'b0, in_ready}, 4'h0);
        check_sig("mid_reset_count", {1'b0, patch_count}, 4'h0);
        check_zero("mid_reset_image");
        reset = 1'b0;
        tick();
        collect(8'hA5, 0, 3);
        check_image(8'hA5, "post_reset_image");
        take_output();
    endtask

    initial begin
        for (int p = 0; p < PV; p++) in_patch[p] = '0;
        test_reset();
        test_full_image();
        test_handoff();
        test_bubbles();
        test_err_last();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
